// File: rtl/axis_frame_checker.sv
// AXI4-Stream sink that checks counter-pattern frames (0 .. FRAME_LEN-1, tlast on
// the final word). Counts accepted frames and erroneous beats and keeps sticky error
// flags for software readback. The run is gated by a GPIO enable level.
//
// Optional build macro: AXIS_CHK_BACKPRESSURE_EN
//   When defined, a 16-bit LFSR gates tready to apply pseudo-random backpressure.
//   When undefined (default), tready depends only on the FSM state.
module axis_frame_checker #(
  parameter int unsigned FRAME_LEN = 512,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned IDX_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clr,
  input  logic             M_AXIS_tvalid,
  output logic             M_AXIS_tready,
  input  logic [31:0]      M_AXIS_tdata,
  input  logic [3:0]       M_AXIS_tkeep,
  input  logic             M_AXIS_tlast,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             data_err,
  output logic             last_err
);

  // Index of the word that must carry tlast.
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StDrain = 2'b10
  } state_e;

  state_e state_q;

  logic [31:0]      exp_q, exp_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             data_err_q, data_err_d;
  logic             last_err_q, last_err_d;

  logic             accepting;
  logic             beat;
  logic             d_bad;
  logic             l_bad;

  // Sink is willing to take data in RUN and while draining the tail of a frame.
  assign accepting = (state_q == StRun) || (state_q == StDrain);

`ifdef AXIS_CHK_BACKPRESSURE_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  // Fibonacci taps 16,14,13,11.
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Free-running LFSR; bit 0 throttles tready roughly half the time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end

  assign M_AXIS_tready = accepting && lfsr_q[0];
`else
  assign M_AXIS_tready = accepting;
`endif

  assign beat = M_AXIS_tvalid && M_AXIS_tready;

  // Run control: drain an in-flight frame to its tlast before going idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (enable) state_q <= StRun;
        end
        StRun: begin
          if (!enable) state_q <= (idx_q == '0) ? StIdle : StDrain;
        end
        StDrain: begin
          if (enable) begin
            state_q <= StRun;
          end else if (beat && M_AXIS_tlast) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Per-beat checks and next-state for pattern tracking, counters and sticky flags.
  always_comb begin
    d_bad       = (M_AXIS_tdata != exp_q) || (M_AXIS_tkeep != 4'hF);
    l_bad       = (M_AXIS_tlast && (idx_q != LastIdx)) ||
                  (!M_AXIS_tlast && (idx_q >= LastIdx));

    exp_d       = exp_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    data_err_d  = data_err_q;
    last_err_d  = last_err_q;

    if (beat) begin
      // One error per beat even when both data and tlast are wrong.
      if ((d_bad || l_bad) && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
      data_err_d = data_err_q | d_bad;
      last_err_d = last_err_q | l_bad;

      if (M_AXIS_tlast) begin
        // tlast always resyncs the pattern, even if it came at the wrong word.
        exp_d = '0;
        idx_d = '0;
        if (frame_cnt_q != '1) begin
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end
      end else begin
        // exp follows the beat count, not the received data, so one bad word
        // yields exactly one error.
        exp_d = exp_q + 32'd1;
        if (idx_q != '1) begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
    end

    // Software clear wins over a same-cycle increment or flag set.
    if (clr) begin
      frame_cnt_d = '0;
      err_cnt_d   = '0;
      data_err_d  = 1'b0;
      last_err_d  = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_q       <= '0;
      idx_q       <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      data_err_q  <= 1'b0;
      last_err_q  <= 1'b0;
    end else begin
      exp_q       <= exp_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      data_err_q  <= data_err_d;
      last_err_q  <= last_err_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign data_err  = data_err_q;
  assign last_err  = last_err_q;

endmodule

// File: tb/tb_axis_frame_checker.sv
// Bench for axis_frame_checker: directed frames into a full-size instance (index 0)
// and a small saturating instance (index 1, FRAME_LEN=4, CNT_W=4). Expected status
// snapshots go into a queue; a negedge monitor pops and compares them.
module tb_axis_frame_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  en;
  logic [1:0]  clr_s;
  logic [1:0]  tvalid;
  logic [1:0]  tlast;
  logic [31:0] tdata [2];
  logic [3:0]  tkeep [2];
  logic [1:0]  tready;
  logic [1:0]  busy;
  logic [1:0]  de;
  logic [1:0]  le;
  logic [15:0] fc0;
  logic [15:0] ec0;
  logic [3:0]  fc1;
  logic [3:0]  ec1;

  always #5 clk = ~clk;

  axis_frame_checker #(
    .FRAME_LEN(512),
    .CNT_W    (16),
    .IDX_W    (16)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (en[0]),
    .clr          (clr_s[0]),
    .M_AXIS_tvalid(tvalid[0]),
    .M_AXIS_tready(tready[0]),
    .M_AXIS_tdata (tdata[0]),
    .M_AXIS_tkeep (tkeep[0]),
    .M_AXIS_tlast (tlast[0]),
    .busy         (busy[0]),
    .frame_cnt    (fc0),
    .err_cnt      (ec0),
    .data_err     (de[0]),
    .last_err     (le[0])
  );

  axis_frame_checker #(
    .FRAME_LEN(4),
    .CNT_W    (4),
    .IDX_W    (16)
  ) u_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (en[1]),
    .clr          (clr_s[1]),
    .M_AXIS_tvalid(tvalid[1]),
    .M_AXIS_tready(tready[1]),
    .M_AXIS_tdata (tdata[1]),
    .M_AXIS_tkeep (tkeep[1]),
    .M_AXIS_tlast (tlast[1]),
    .busy         (busy[1]),
    .frame_cnt    (fc1),
    .err_cnt      (ec1),
    .data_err     (de[1]),
    .last_err     (le[1])
  );

  typedef struct {
    string name;
    int    sel;
    bit    tmo;
    logic  busy;
    logic  tready;
    int    fc;
    int    ec;
    logic  de;
    logic  le;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   a_fc;
  int   a_ec;

  // Monitor: compare every queued expectation against the DUT status.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      n_chk++;
      if (cur.tmo) begin
        n_fail++;
        $display("FAIL %s: no handshake within budget, got tready=0 required tready=1",
                 cur.name);
      end else begin
        a_fc = (cur.sel == 0) ? int'(fc0) : int'(fc1);
        a_ec = (cur.sel == 0) ? int'(ec0) : int'(ec1);
        if ((busy[cur.sel] !== cur.busy) || (tready[cur.sel] !== cur.tready) ||
            (a_fc != cur.fc) || (a_ec != cur.ec) ||
            (de[cur.sel] !== cur.de) || (le[cur.sel] !== cur.le)) begin
          n_fail++;
          $display({"FAIL %s: got busy=%0b tready=%0b frame_cnt=%0d err_cnt=%0d ",
                    "data_err=%0b last_err=%0b, required busy=%0b tready=%0b ",
                    "frame_cnt=%0d err_cnt=%0d data_err=%0b last_err=%0b"},
                   cur.name, busy[cur.sel], tready[cur.sel], a_fc, a_ec,
                   de[cur.sel], le[cur.sel], cur.busy, cur.tready, cur.fc, cur.ec,
                   cur.de, cur.le);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int sel, input logic b, input logic r,
                       input int fc, input int ec, input logic d, input logic l);
    exp_t e;
    e.name   = name;
    e.sel    = sel;
    e.tmo    = 1'b0;
    e.busy   = b;
    e.tready = r;
    e.fc     = fc;
    e.ec     = ec;
    e.de     = d;
    e.le     = l;
    sb_q.push_back(e);
  endtask

  // Hold one beat on the bus until it is accepted (bounded wait).
  task automatic send_beat(input int sel, input logic [31:0] d, input logic [3:0] k,
                           input logic l);
    bit   got;
    exp_t e;
    got         = 1'b0;
    tvalid[sel] = 1'b1;
    tdata[sel]  = d;
    tkeep[sel]  = k;
    tlast[sel]  = l;
    for (int n = 0; n < 2000 && !got; n++) begin
      @(negedge clk);
      got = tready[sel];
      @(posedge clk);
      #1;
    end
    if (!got) begin
      e.name = $sformatf("timeout_beat_sel%0d_data%0d", sel, d);
      e.sel  = sel;
      e.tmo  = 1'b1;
      sb_q.push_back(e);
    end
  endtask

  // Words first..last_word carry their own index; tlast on last_at; bad_idx is corrupted.
  task automatic send_frame(input int sel, input int first, input int last_word,
                            input int last_at, input int bad_idx, input bit gaps);
    for (int i = first; i <= last_word; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        tvalid[sel] = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_beat(sel, (i == bad_idx) ? 32'hDEAD_BEEF : 32'(i), 4'hF, i == last_at);
    end
    tvalid[sel] = 1'b0;
    tlast[sel]  = 1'b0;
  endtask

  task automatic clr_pulse(input int sel);
    clr_s[sel] = 1'b1;
    tick();
    clr_s[sel] = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 2'b00;
    clr_s  = 2'b00;
    tvalid = 2'b00;
    tlast  = 2'b00;
    for (int s = 0; s < 2; s++) begin
      tdata[s] = '0;
      tkeep[s] = 4'hF;
    end
    repeat (3) tick();
    check("reset_main", 0, 0, 0, 0, 0, 0, 0);
    check("reset_sat", 1, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // tready rises the cycle after enable is sampled.
    en[0] = 1'b1;
    check("idle_before_edge", 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("run_after_enable", 0, 1, 1, 0, 0, 0, 0);

    send_frame(0, 0, 511, 511, -1, 0);
    check("clean_frame", 0, 1, 1, 1, 0, 0, 0);

    for (int f = 0; f < 3; f++) send_frame(0, 0, 511, 511, -1, 1);
    check("three_frames_gaps", 0, 1, 1, 4, 0, 0, 0);

    clr_pulse(0);
    check("clr_a", 0, 1, 1, 0, 0, 0, 0);

    send_frame(0, 0, 511, 511, 100, 0);
    check("corrupt_word100", 0, 1, 1, 1, 1, 1, 0);
    send_frame(0, 0, 511, 511, -1, 0);
    check("clean_after_corrupt", 0, 1, 1, 2, 1, 1, 0);
    clr_pulse(0);
    check("clr_b", 0, 1, 1, 0, 0, 0, 0);

    send_frame(0, 0, 299, 299, -1, 0);
    check("early_tlast", 0, 1, 1, 1, 1, 0, 1);
    send_frame(0, 0, 511, 511, -1, 0);
    check("clean_after_early", 0, 1, 1, 2, 1, 0, 1);
    clr_pulse(0);

    send_frame(0, 0, 513, 513, -1, 0);
    check("long_frame_514", 0, 1, 1, 1, 3, 0, 1);
    clr_pulse(0);
    check("clr_c", 0, 1, 1, 0, 0, 0, 0);

    // clr held during a bad tlast beat: nothing may count.
    send_frame(0, 0, 510, -1, -1, 0);
    clr_s[0] = 1'b1;
    send_beat(0, 32'd511, 4'h0, 1'b1);
    clr_s[0]  = 1'b0;
    tvalid[0] = 1'b0;
    tlast[0]  = 1'b0;
    check("clr_priority", 0, 1, 1, 0, 0, 0, 0);

    // Enable dropped mid-frame: drain to tlast, then idle.
    send_frame(0, 0, 199, -1, -1, 0);
    en[0] = 1'b0;
    check("drain_entry", 0, 1, 1, 0, 0, 0, 0);
    send_frame(0, 200, 510, -1, -1, 0);
    check("drain_hold", 0, 1, 1, 0, 0, 0, 0);
    send_frame(0, 511, 511, 511, -1, 0);
    check("drain_exit", 0, 0, 0, 1, 0, 0, 0);

    // Enable dropped between frames: straight back to idle.
    en[0] = 1'b1;
    tick();
    check("rerun", 0, 1, 1, 1, 0, 0, 0);
    en[0] = 1'b0;
    tick();
    check("idle_between_frames", 0, 0, 0, 1, 0, 0, 0);

    // Saturation on the 4-bit instance: one data error per 4-word frame.
    en[1] = 1'b1;
    for (int f = 0; f < 14; f++) send_frame(1, 0, 3, 3, 1, 0);
    check("sat_14", 1, 1, 1, 14, 14, 1, 0);
    send_frame(1, 0, 3, 3, 1, 0);
    check("sat_15", 1, 1, 1, 15, 15, 1, 0);
    for (int f = 0; f < 2; f++) send_frame(1, 0, 3, 3, 1, 0);
    check("sat_hold", 1, 1, 1, 15, 15, 1, 0);

    // Reset mid-frame, then the remainder of that frame is checked from exp=0.
    en[0] = 1'b1;
    send_frame(0, 0, 49, -1, 10, 0);
    check("pre_reset", 0, 1, 1, 1, 1, 1, 0);
    rst_n = 1'b0;
    tick();
    check("reset_mid_main", 0, 0, 0, 0, 0, 0, 0);
    check("reset_mid_sat", 1, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    send_frame(0, 50, 511, 511, -1, 0);
    check("partial_after_reset", 0, 1, 1, 1, 462, 1, 1);

    en = 2'b00;
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hang guard.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axis_frame_checker.md
Name: axis_frame_checker

Overview:
- AXI4-Stream sink that receives counter-pattern frames, e.g. from a DMA MM2S channel in a loopback test.
- Each frame carries words 0, 1, …, FRAME_LEN-1, with tlast on the final word.
- Checks data, tkeep and tlast placement, counts frames and errors, and exposes sticky error flags for PS/GPIO readback.
- Start and stop are gated by a GPIO enable bit.

Parameters:
FRAME_LEN, 512, expected words per frame (≥2)
CNT_W, 16, width of frame_cnt and err_cnt
IDX_W, 16, width of the internal word index (must hold FRAME_LEN)

Ports:
clk  in  1  clock
rst_n  in  1  reset
enable  in  1  GPIO run enable; level-sensitive
clr  in  1  synchronous clear of counters and sticky flags
M_AXIS_tvalid  in  1  upstream data valid
M_AXIS_tready  out  1  sink ready
M_AXIS_tdata  in  32  payload
M_AXIS_tkeep  in  4  byte enables; 4'hF expected
M_AXIS_tlast  in  1  end-of-frame marker
busy  out  1  state != IDLE
frame_cnt  out  CNT_W  accepted tlast beats, saturating
err_cnt  out  CNT_W  erroneous beats, saturating
data_err  out  1  sticky: tdata or tkeep mismatch seen
last_err  out  1  sticky: tlast misplaced

Behaviour:
- Clock clk; reset rst_n, synchronous, active-low.
- Reset values: tready=0, busy=0, frame_cnt=0, err_cnt=0, data_err=0, last_err=0. Internal: exp=0, idx=0, state=IDLE.
- A beat is accepted only when tvalid && tready. No other cycle changes exp, idx or the counters.
- tready is driven combinationally from the state register only: tready = (state==RUN || state==DRAIN). It never depends on tvalid.
- FSM:
  - IDLE: when enable=1, go to RUN next cycle, so tready rises one cycle after enable is sampled high.
  - RUN: if enable=0 and idx==0, go to IDLE. If enable=0 and idx!=0, go to DRAIN.
  - DRAIN: if an accepted beat has tlast=1, go to IDLE. enable returning to 1 in DRAIN moves the FSM back to RUN.
  - Default or illegal state: go to IDLE.
- Per accepted beat:
  - d_bad = (tdata != exp) || (tkeep != 4'hF).
  - l_bad = (tlast && idx != FRAME_LEN-1) || (!tlast && idx >= FRAME_LEN-1).
  - If d_bad or l_bad: err_cnt += 1, only once per beat even if both are set.
  - data_err |= d_bad; last_err |= l_bad.
  - If tlast: exp←0, idx←0, frame_cnt+=1, regardless of l_bad (frames always resync on tlast).
  - Otherwise: exp←exp+1 (32-bit wrap); idx←idx+1, saturating at all-ones.
  - exp is not resynced to received data, so a single corrupted word produces exactly 1 error.
- Both counters saturate at all-ones and never wrap.
- clr=1: counters and sticky flags are cleared that cycle. clr has priority over a simultaneous increment or set. exp, idx and state are unaffected.
- rst_n=0 mid-frame: everything returns to reset values next edge. A partial frame arriving after reset is checked from exp=0, so it produces errors; this is expected behaviour.

Optional Feature:
- Macro: AXIS_CHK_BACKPRESSURE_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded to 16'hACE1 on reset and advances every cycle.
  - tready = (state==RUN || state==DRAIN) && lfsr[0], giving pseudo-random backpressure of about 50%.
  - Checking rules are unchanged.
- Undefined: no LFSR; tready is as above.

Test Plan:
- enable=1, one clean 512-word frame (0..511, tlast on 511, tkeep=F), tvalid continuous → frame_cnt=1, err_cnt=0, both flags 0, tready asserted from cycle after enable.
- Three back-to-back clean frames with tvalid toggling randomly → frame_cnt=3, err_cnt=0; no beat accepted while tvalid=0.
- Word 100 corrupted to 32'hDEAD_BEEF in a clean frame → err_cnt=1, data_err=1, last_err=0, frame_cnt=1; next frame clean adds no errors. Then clr pulse → both counters 0, flags 0.
- tlast on word 299, then a clean frame → err_cnt=1, last_err=1, frame_cnt=2. Separately, a 514-word frame with tlast on 513 → err_cnt=3 (beats 511..513), last_err=1.
- enable dropped at word 200 → busy stays 1 and tready stays 1 until tlast at 511 is accepted, then tready=0 and busy=0 the next cycle; enable dropped between frames → IDLE next cycle.
- err_cnt preloaded near saturation via repeated bad frames with CNT_W=4 → err_cnt holds 15; rst_n pulse mid-frame → all outputs 0 next cycle.
